// File: rtl/kbd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : kbd_ctrl_if
// Description : Bundles the keyboard controller's FIFO, ROM and status signals.
//               master : kbd_ctrl side (pops FIFO, drives ROM address, status)
//               slave  : environment side (FIFO head, ROM data, observes status)
//   ps2_data   [7:0]       byte at head of receiver FIFO
//   ps2_ready              FIFO non-empty
//   nextdata_n             active-low pop strobe, one-cycle pulse
//   rom_scan   [7:0]       scan code presented to the ASCII rom
//   rom_ascii  [7:0]       rom result for rom_scan
//   key_down               a key is currently held
//   cur_scan   [7:0]       scan code of last pressed key
//   cur_ascii  [7:0]       ASCII of last pressed key
//   press_cnt  [CNT_W-1:0] distinct key press count
// Revision    : 1.0 - initial release
// ============================================================================
interface kbd_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       ps2_data;
    logic             ps2_ready;
    logic             nextdata_n;
    logic [7:0]       rom_scan;
    logic [7:0]       rom_ascii;
    logic             key_down;
    logic [7:0]       cur_scan;
    logic [7:0]       cur_ascii;
    logic [CNT_W-1:0] press_cnt;

    modport master (
        input  ps2_data, ps2_ready, rom_ascii,
        output nextdata_n, rom_scan, key_down, cur_scan, cur_ascii, press_cnt
    );

    modport slave (
        output ps2_data, ps2_ready, rom_ascii,
        input  nextdata_n, rom_scan, key_down, cur_scan, cur_ascii, press_cnt
    );
endinterface
`default_nettype wire

// File: rtl/kbd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kbd_ctrl
// Description : PS/2 keyboard sequencer. Pops raw bytes from the receiver
//               FIFO, strips F0 (break) and E0 (extended) prefixes, drives
//               the scan-code->ASCII rom, tracks the held key and counts
//               distinct key presses.
// Ports       : clk  - system clock, rising edge
//               clrn - asynchronous active-low reset
//               bus  - kbd_ctrl_if.master (FIFO, rom and status signals)
// Parameters  : CNT_W    - press counter width (wraps)
//               BRK_CODE - break prefix byte
//               EXT_CODE - extended prefix byte
// Build macro : KBD_EXT_FILTER_EN - when defined, the key sequence following
//               an E0 prefix (including an F0 and its byte) is discarded.
//               When undefined, E0 is dropped and later bytes act normally.
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_ctrl #(
    parameter int         CNT_W    = 8,
    parameter logic [7:0] BRK_CODE = 8'hF0,
    parameter logic [7:0] EXT_CODE = 8'hE0
) (
    input  logic          clk,
    input  logic          clrn,
    kbd_ctrl_if.master    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no key held
        ST_HELD  = 2'd1,   // key held
        ST_BRK_I = 2'd2,   // break prefix seen with no key held
        ST_BRK_H = 2'd3    // break prefix seen while a key is held
    } state_t;

    state_t           r_state;
    logic [7:0]       r_byte;
    logic             r_byte_vld;
    logic             r_nextdata_n;
    logic             r_key_down;
    logic [7:0]       r_cur_scan;
    logic [7:0]       r_cur_ascii;
    logic [CNT_W-1:0] r_press_cnt;
`ifdef KBD_EXT_FILTER_EN
    logic             r_ext;
`endif

    // The rom is combinational, so its result is valid in the processing
    // cycle while r_byte is held.
    assign bus.rom_scan   = r_byte;
    assign bus.nextdata_n = r_nextdata_n;
    assign bus.key_down   = r_key_down;
    assign bus.cur_scan   = r_cur_scan;
    assign bus.cur_ascii  = r_cur_ascii;
    assign bus.press_cnt  = r_press_cnt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state      <= ST_IDLE;
            r_byte       <= 8'h00;
            r_byte_vld   <= 1'b0;
            r_nextdata_n <= 1'b1;
            r_key_down   <= 1'b0;
            r_cur_scan   <= 8'h00;
            r_cur_ascii  <= 8'h00;
            r_press_cnt  <= '0;
`ifdef KBD_EXT_FILTER_EN
            r_ext        <= 1'b0;
`endif
        end else begin
            // Pop strobe is always a single-cycle pulse.
            r_nextdata_n <= 1'b1;
            if (r_byte_vld) begin
                // Processing cycle; fetch is blocked here, which spaces
                // pops at least two cycles apart.
                r_byte_vld <= 1'b0;
                if (r_byte == EXT_CODE) begin
`ifdef KBD_EXT_FILTER_EN
                    r_ext <= 1'b1;
`endif
                end
`ifdef KBD_EXT_FILTER_EN
                else if (r_ext) begin
                    // Swallow the extended key; an F0 keeps the sequence
                    // open until its following byte arrives.
                    if (r_byte != BRK_CODE) begin
                        r_ext <= 1'b0;
                    end
                end
`endif
                else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (r_byte == BRK_CODE) begin
                                r_state <= ST_BRK_I;
                            end else begin
                                r_state     <= ST_HELD;
                                r_key_down  <= 1'b1;
                                r_cur_scan  <= r_byte;
                                r_cur_ascii <= bus.rom_ascii;
                                r_press_cnt <= r_press_cnt + 1'b1;
                            end
                        end
                        ST_HELD: begin
                            if (r_byte == BRK_CODE) begin
                                r_state <= ST_BRK_H;
                            end else if (r_byte != r_cur_scan) begin
                                // A repeat of the held key is typematic and
                                // is neither latched nor counted.
                                r_cur_scan  <= r_byte;
                                r_cur_ascii <= bus.rom_ascii;
                                r_press_cnt <= r_press_cnt + 1'b1;
                            end
                        end
                        ST_BRK_I: begin
                            if (r_byte != BRK_CODE) begin
                                r_state <= ST_IDLE;
                            end
                        end
                        ST_BRK_H: begin
                            if (r_byte == r_cur_scan) begin
                                r_state    <= ST_IDLE;
                                r_key_down <= 1'b0;
                            end else if (r_byte != BRK_CODE) begin
                                // Some other key was released; keep holding.
                                r_state <= ST_HELD;
                            end
                        end
                        default: begin
                            r_state    <= ST_IDLE;
                            r_key_down <= 1'b0;
                        end
                    endcase
                end
            end else if (bus.ps2_ready && r_nextdata_n) begin
                r_byte       <= bus.ps2_data;
                r_byte_vld   <= 1'b1;
                r_nextdata_n <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kbd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kbd_ctrl
// Description : Self-checking bench for kbd_ctrl. A byte queue models the
//               receiver FIFO, a table models the rom, and a key-event model
//               predicts the status outputs checked on every cycle.
// Build macro : KBD_EXT_FILTER_EN selects the extended-filter expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kbd_ctrl;

    logic clk;
    logic clrn;

    kbd_ctrl_if #(.CNT_W(8)) bus ();

    kbd_ctrl #(.CNT_W(8), .BRK_CODE(8'hF0), .EXT_CODE(8'hE0)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int pops   = 0;

    logic [7:0] q[$];

    // Model state: what a keyboard observer knows about the key stream.
    bit         m_down;
    bit         m_brk;
    bit         m_skip;
    logic [7:0] m_scan;
    logic [7:0] m_ascii;
    int         m_cnt;
    bit         prev_nd;

    function automatic logic [7:0] rom_fn(input logic [7:0] s);
        case (s)
            8'h1C:   rom_fn = 8'h65;
            8'h16:   rom_fn = 8'h33;
            8'h45:   rom_fn = 8'h32;
            8'h15:   rom_fn = 8'h71;
            8'h75:   rom_fn = 8'h38;
            default: rom_fn = s + 8'h20;
        endcase
    endfunction

    assign bus.rom_ascii = rom_fn(bus.rom_scan);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one popped byte to the model.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) begin
`ifdef KBD_EXT_FILTER_EN
            m_skip = 1'b1;
`endif
            return;
        end
        if (m_skip) begin
            if (b != 8'hF0) m_skip = 1'b0;
            return;
        end
        if (b == 8'hF0) begin
            m_brk = 1'b1;
            return;
        end
        if (m_brk) begin
            m_brk = 1'b0;
            if (m_down && b == m_scan) m_down = 1'b0;
        end else if (!m_down || b != m_scan) begin
            m_down  = 1'b1;
            m_scan  = b;
            m_ascii = rom_fn(b);
            m_cnt   = (m_cnt + 1) % 256;
        end
    endtask

    // FIFO head presented just after each falling edge.
    always @(negedge clk) begin
        #1;
        bus.ps2_ready = (q.size() != 0);
        bus.ps2_data  = (q.size() != 0) ? q[0] : 8'h00;
    end

    // Compare process: outputs against the model every cycle, then pop.
    always @(negedge clk) begin
        if (!clrn) begin
            m_down = 0; m_brk = 0; m_skip = 0;
            m_scan = 8'h00; m_ascii = 8'h00; m_cnt = 0;
            prev_nd = 1'b1;
        end else begin
            chk("key_down", {31'd0, bus.key_down}, {31'd0, m_down});
            chk("cur_scan", {24'd0, bus.cur_scan}, {24'd0, m_scan});
            chk("cur_ascii", {24'd0, bus.cur_ascii}, {24'd0, m_ascii});
            chk("press_cnt", {24'd0, bus.press_cnt}, m_cnt[31:0]);
            if (!bus.nextdata_n) begin
                chk("pop_not_back_to_back", {31'd0, prev_nd}, 32'd1);
                chk("pop_nonempty", {31'd0, q.size() != 0}, 32'd1);
                if (q.size() != 0) begin
                    model_byte(q.pop_front());
                    pops++;
                end
            end
            prev_nd = bus.nextdata_n;
        end
    end

    task automatic push(input logic [7:0] b);
        @(posedge clk); #2;
        q.push_back(b);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {31'd0, n >= 3000}, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        clrn = 1'b0;
        q.delete();
        @(negedge clk); #2;
        clrn = 1'b1;
    endtask

    task automatic expect_out(input string tag, input bit kd, input logic [7:0] sc,
                              input logic [7:0] as, input logic [7:0] cnt);
        chk({tag, "_key_down"},  {31'd0, bus.key_down},  {31'd0, kd});
        chk({tag, "_cur_scan"},  {24'd0, bus.cur_scan},  {24'd0, sc});
        chk({tag, "_cur_ascii"}, {24'd0, bus.cur_ascii}, {24'd0, as});
        chk({tag, "_press_cnt"}, {24'd0, bus.press_cnt}, {24'd0, cnt});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int found;
        int last;
        int lows;
        bus.ps2_ready = 1'b0;
        bus.ps2_data  = 8'h00;
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_nextdata_n", {31'd0, bus.nextdata_n}, 32'd1);
        expect_out("rst", 1'b0, 8'h00, 8'h00, 8'h00);
        #2 clrn = 1'b1;

        // Single key press, then reset during the next fetch.
        push(8'h1C);
        drain();
        expect_out("press_1c", 1'b1, 8'h1C, 8'h65, 8'h01);
        push(8'h15);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(posedge clk); #1;
            if (!bus.nextdata_n) found = 1;
        end
        chk("midfetch_seen", found[31:0], 32'd1);
        clrn = 1'b0;
        #1;
        chk("midrst_nextdata_n", {31'd0, bus.nextdata_n}, 32'd1);
        expect_out("midrst", 1'b0, 8'h00, 8'h00, 8'h00);
        @(negedge clk); #2;
        clrn = 1'b1;
        drain();
        // 15 was never popped, so it is fetched again after reset.
        expect_out("after_midrst", 1'b1, 8'h15, 8'h71, 8'h01);

        // Typematic repeats then release.
        do_reset();
        p0 = pops;
        push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
        drain();
        chk("typematic_pops", pops - p0, 32'd5);
        expect_out("typematic", 1'b0, 8'h1C, 8'h65, 8'h01);

        // Two keys, release second, press first again.
        do_reset();
        push(8'h15); push(8'h16); push(8'hF0); push(8'h16);
        drain();
        expect_out("two_keys", 1'b0, 8'h16, 8'h33, 8'h02);
        push(8'h15);
        drain();
        chk("two_keys_again_cnt", {24'd0, bus.press_cnt}, 32'd3);

        // Stray release in IDLE.
        do_reset();
        push(8'hF0); push(8'h1C);
        drain();
        expect_out("stray_brk", 1'b0, 8'h00, 8'h00, 8'h00);

        // Counter wrap.
        do_reset();
        for (int i = 0; i < 255; i++) push((i % 2) ? 8'h11 : 8'h10);
        drain();
        chk("wrap_ff", {24'd0, bus.press_cnt}, 32'hFF);
        push(8'h45);
        drain();
        expect_out("wrap", 1'b1, 8'h45, 8'h32, 8'h00);

        // Extended prefix sequence.
        do_reset();
        push(8'hE0); push(8'h75); push(8'hF0); push(8'h75);
        drain();
`ifdef KBD_EXT_FILTER_EN
        expect_out("ext_seq", 1'b0, 8'h00, 8'h00, 8'h00);
`else
        expect_out("ext_seq", 1'b0, 8'h75, 8'h38, 8'h01);
`endif

        // Pop pacing with ready held high across four bytes.
        do_reset();
        @(posedge clk); #2;
        for (int i = 0; i < 4; i++) q.push_back(8'h1C);
        last = -10;
        lows = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (!bus.nextdata_n) begin
                if (lows > 0) chk("pop_spacing", cyc - last, 32'd2);
                last = cyc;
                lows++;
            end
        end
        chk("pop_count4", lows[31:0], 32'd4);
        drain();

        // Randomized byte stream with idle gaps.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0: push(8'h1C);
                1: push(8'h15);
                2: push(8'h16);
                3: push(8'h45);
                4: push(8'h75);
                5, 6: push(8'hF0);
                7: push(8'hE0);
                8: push(8'($urandom_range(0, 255)));
                default: begin
                    drain();
                    repeat ($urandom_range(1, 5)) @(posedge clk);
                end
            endcase
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
